// File: rtl/uart_tx.sv
// uart_tx - 8-N-1 UART transmitter with optional parity and a small TX FIFO.
//
// Bytes written by host logic are queued in a FIFO_DEPTH-entry FIFO and
// serialised LSB first: start bit, D0..D7, optional parity bit, stop bit.
// When the FIFO still holds data at the end of a stop bit, the next frame's
// start bit follows immediately, so a burst leaves the line back-to-back.
//
// Ports:
//   clk_i      system clock (122.61 MHz nominal)
//   rst_i      synchronous active-high reset
//   wr_i       write strobe; data_i is queued when wr_i && !full_o
//   data_i     byte to transmit
//   full_o     FIFO holds FIFO_DEPTH entries
//   busy_o     a frame is in flight or the FIFO is non-empty
//   uart_tx_o  registered serial line, idles high
module uart_tx #(
  parameter int CLK_FREQ   = 122610000,
  parameter int BAUD_RATE  = 115200,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       wr_i,
  input  logic [7:0] data_i,
  output logic       full_o,
  output logic       busy_o,
  output logic       uart_tx_o
);

  localparam int          CLKS_PER_BAUD = CLK_FREQ / BAUD_RATE;
  localparam logic [15:0] BAUD_LAST     = 16'(CLKS_PER_BAUD - 1);
  localparam int          AW            = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C       = (AW+1)'(FIFO_DEPTH);
  localparam logic        PAR_ODD_C     = (PARITY_ODD != 0);
  localparam logic        PAR_EN_C      = (PARITY_EN != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  function automatic logic parity_of(input logic [7:0] b);
    return (^b) ^ PAR_ODD_C;
  endfunction

  // FIFO
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   cnt_q;
  logic          push;
  logic          pop;
  logic          empty;
  logic [7:0]    head;

  assign full_o = (cnt_q == DEPTH_C);
  assign empty  = (cnt_q == '0);
  assign push   = wr_i && !full_o;
  assign head   = mem[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr_q] <= data_i;
    end
  end

  // Pointers wrap naturally since FIFO_DEPTH is a power of two.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      cnt_q <= cnt_q + 1'b1;
      else if (pop && !push) cnt_q <= cnt_q - 1'b1;
    end
  end

  // Serialiser state
  state_t      state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        par_q, par_d;
  logic        tx_q, tx_d;
  logic        rdy_p0;
  logic        bit_end;

  assign bit_end   = (baud_q == BAUD_LAST);
  assign busy_o    = (state_q != S_IDLE) || !empty;
  assign uart_tx_o = tx_q;

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    shift_d = shift_q;
    bit_d   = bit_q;
    par_d   = par_q;
    baud_d  = (state_q == S_IDLE || bit_end) ? 16'd0 : baud_q + 16'd1;

    case (state_q)
      S_IDLE: begin
        // rdy_p0 gives the FIFO write one cycle to settle before the pop,
        // so a fresh write reaches the line two edges after it is taken.
        if (rdy_p0 && !empty) begin
          pop     = 1'b1;
          shift_d = head;
          par_d   = parity_of(head);
          bit_d   = 3'd0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = PAR_EN_C ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (bit_end) state_d = S_STOP;
      end
      S_STOP: begin
        if (bit_end) begin
          if (!empty) begin
            pop     = 1'b1;
            shift_d = head;
            par_d   = parity_of(head);
            bit_d   = 3'd0;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Line value follows the next state so it moves on the same edge.
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = par_d;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      baud_q  <= 16'd0;
      bit_q   <= 3'd0;
      tx_q    <= 1'b1;
      rdy_p0  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      rdy_p0  <= !empty;
    end
  end

  always_ff @(posedge clk_i) begin
    shift_q <= shift_d;
    par_q   <= par_d;
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx - directed self-checking bench for uart_tx.
//
// Four instances share one clock: u0 and u3 without parity, u1 with even
// parity, u2 with odd parity. Frames on different instances are started on
// the same edge so their bits can be sampled at common mid-baud instants.
module tb_uart_tx;

  logic clk;
  logic rst0, rst1, rst2, rst3;
  logic wr0, wr1, wr2, wr3;
  logic [7:0] d0, d1, d2, d3;
  logic full0, full1, full2, full3;
  logic busy0, busy1, busy2, busy3;
  logic tx0, tx1, tx2, tx3;

  int checks = 0;
  int fails  = 0;
  int t      = 0;

  uart_tx u0 (.clk_i(clk), .rst_i(rst0), .wr_i(wr0), .data_i(d0),
              .full_o(full0), .busy_o(busy0), .uart_tx_o(tx0));
  uart_tx #(.PARITY_EN(1), .PARITY_ODD(0)) u1 (
              .clk_i(clk), .rst_i(rst1), .wr_i(wr1), .data_i(d1),
              .full_o(full1), .busy_o(busy1), .uart_tx_o(tx1));
  uart_tx #(.PARITY_EN(1), .PARITY_ODD(1)) u2 (
              .clk_i(clk), .rst_i(rst2), .wr_i(wr2), .data_i(d2),
              .full_o(full2), .busy_o(busy2), .uart_tx_o(tx2));
  uart_tx u3 (.clk_i(clk), .rst_i(rst3), .wr_i(wr3), .data_i(d3),
              .full_o(full3), .busy_o(busy3), .uart_tx_o(tx3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h (t=%0d)", tag, obs, exp, t);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input int target);
    while (t < target) begin
      step();
      t++;
    end
  endtask

  // Frame bit n of a no-parity frame: 0 start, 1..8 data LSB first, 9 stop.
  function automatic logic fbit(input logic [7:0] b, input int n);
    if (n == 0) return 1'b0;
    else if (n <= 8) return b[n-1];
    else return 1'b1;
  endfunction

  task automatic chk_frame(input int which, input string tag, input logic [7:0] b,
                           input int base, input int n_lo, input int n_hi);
    for (int n = n_lo; n <= n_hi; n++) begin
      go(base + 532 + n * 1064);
      chk(tag, (which == 0) ? tx0 : tx3, fbit(b, n));
    end
  endtask

  logic [9:0]  a5_frame;
  logic [10:0] even_frame;
  logic [10:0] odd_frame;

  initial begin
    a5_frame   = 10'b1101001010;
    even_frame = 11'b11000001110;
    odd_frame  = 11'b10000001110;
    {rst0, rst1, rst2, rst3} = 4'b1111;
    {wr0, wr1, wr2, wr3}     = 4'b0000;
    d0 = 8'h00; d1 = 8'h00; d2 = 8'h00; d3 = 8'h00;
    step();
    step();
    {rst0, rst1, rst2, rst3} = 4'b0000;
    step();
    chk("rst_tx0", tx0, 1'b1);
    chk("rst_full0", full0, 1'b0);
    chk("rst_busy0", busy0, 1'b0);
    chk("rst_tx1", tx1, 1'b1);
    chk("rst_busy3", busy3, 1'b0);
    chk("rst_full3", full3, 1'b0);

    // Phase A: 0xA5 on u0, 0x07 on both parity instances, burst 00/FF/55 on u3.
    wr0 = 1'b1; d0 = 8'hA5;
    wr1 = 1'b1; d1 = 8'h07;
    wr2 = 1'b1; d2 = 8'h07;
    wr3 = 1'b1; d3 = 8'h00;
    step();
    wr0 = 1'b0; wr1 = 1'b0; wr2 = 1'b0;
    d3 = 8'hFF;
    step();
    chk("t1_idle_k1", tx0, 1'b1);
    d3 = 8'h55;
    step();
    wr3 = 1'b0;
    chk("t1_fall_k2", tx0, 1'b0);
    chk("t4_fall_even", tx1, 1'b0);
    chk("t2_fall_first", tx3, 1'b0);
    t = 0;

    for (int n = 0; n <= 9; n++) begin
      go(532 + n * 1064);
      chk("t1_a5_bit", tx0, a5_frame[n]);
      chk("t4_even_bit", tx1, even_frame[n]);
      chk("t4_odd_bit", tx2, odd_frame[n]);
      chk("t2_00_bit", tx3, fbit(8'h00, n));
    end
    go(10639);
    chk("t1_busy_before", busy0, 1'b1);
    chk("t2_stop_before", tx3, 1'b1);
    go(10640);
    chk("t1_busy_drop", busy0, 1'b0);
    chk("t1_line_idle", tx0, 1'b1);
    chk("t2_start2_edge", tx3, 1'b0);
    chk("t4_busy_mid", busy1, 1'b1);
    go(11172);
    chk("t4_even_stop", tx1, even_frame[10]);
    chk("t4_odd_stop", tx2, odd_frame[10]);
    chk("t2_ff_bit", tx3, fbit(8'hFF, 0));
    go(11703);
    chk("t4_even_busy_before", busy1, 1'b1);
    chk("t4_odd_busy_before", busy2, 1'b1);
    go(11704);
    chk("t4_even_busy_drop", busy1, 1'b0);
    chk("t4_odd_busy_drop", busy2, 1'b0);
    chk_frame(3, "t2_ff_bit", 8'hFF, 10640, 1, 9);
    go(21279);
    chk("t2_stop2_before", tx3, 1'b1);
    go(21280);
    chk("t2_start3_edge", tx3, 1'b0);
    chk_frame(3, "t2_55_bit", 8'h55, 21280, 0, 9);
    go(31919);
    chk("t2_busy_before", busy3, 1'b1);
    go(31920);
    chk("t2_busy_drop", busy3, 1'b0);
    chk("t2_line_idle", tx3, 1'b1);

    // Phase B: six writes to u0 (last dropped); three to u3, then reset mid-D3.
    for (int i = 0; i < 6; i++) begin
      wr0 = 1'b1; d0 = 8'(8'h10 + i);
      wr3 = (i < 3); d3 = 8'(8'h31 + i);
      step();
      chk("t3_full", full0, (i >= 4) ? 1'b1 : 1'b0);
      if (i == 1) chk("t3_idle_k1", tx0, 1'b1);
      if (i == 2) begin
        chk("t3_fall_k2", tx0, 1'b0);
        chk("t5_fall_k2", tx3, 1'b0);
      end
    end
    wr0 = 1'b0; wr3 = 1'b0;
    t = 3;

    chk_frame(0, "t3_10_bit", 8'h10, 0, 0, 3);
    go(4787);
    chk("t5_d3_before_rst", tx3, fbit(8'h31, 4));
    rst3 = 1'b1;
    step();
    t++;
    rst3 = 1'b0;
    chk("t5_tx_after_rst", tx3, 1'b1);
    chk("t5_full_after_rst", full3, 1'b0);
    chk("t5_busy_after_rst", busy3, 1'b0);
    chk_frame(0, "t3_10_bit", 8'h10, 0, 4, 9);

    go(10639);
    chk("t6_full_before", full0, 1'b1);
    wr0 = 1'b1; d0 = 8'h99;
    step();
    t++;
    wr0 = 1'b0;
    chk("t6_full_after", full0, 1'b0);
    chk("t6_next_start", tx0, 1'b0);
    chk("t5_no_frame2", tx3, 1'b1);
    chk("t5_still_idle", busy3, 1'b0);

    for (int f = 1; f <= 4; f++) begin
      chk_frame(0, "t3_seq_bit", 8'(8'h10 + f), f * 10640, 0, 9);
    end
    go(53199);
    chk("t3_busy_before", busy0, 1'b1);
    go(53200);
    chk("t3_busy_drop", busy0, 1'b0);
    chk("t3_line_idle", tx0, 1'b1);
    go(53800);
    chk("t6_no_extra_frame", tx0, 1'b1);
    chk("t6_busy_idle", busy0, 1'b0);
    chk("t5_line_idle_end", tx3, 1'b1);
    chk("t5_busy_end", busy3, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
